// File: rtl/uart_tx_if.sv
// Transmit-side bus for uart_tx: push handshake, serial line and FIFO status.
interface uart_tx_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 3
);
  logic [DATA_W-1:0] data_i;
  logic              data_valid_strb_i;
  logic              ready_o;
  logic              tx_o;
  logic              busy_o;
  logic [CNT_W-1:0]  fifo_count_o;
  logic              overflow_strb_o;

  modport master (
    output data_i, data_valid_strb_i,
    input  ready_o, tx_o, busy_o, fifo_count_o, overflow_strb_o
  );

  modport slave (
    input  data_i, data_valid_strb_i,
    output ready_o, tx_o, busy_o, fifo_count_o, overflow_strb_o
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: small push FIFO feeding an 8N1-style frame serializer.
module uart_tx #(
  parameter int unsigned UART_DATA_LENGTH           = 8,
  parameter int unsigned TX_COUNTER_BITWIDTH        = 3,
  parameter int unsigned BAUD_COUNTS_PER_BIT        = 521,
  parameter int unsigned BAUD_RATE_COUNTER_BITWIDTH = 10,
  parameter int unsigned FIFO_DEPTH                 = 4,
  parameter int unsigned FIFO_ADDR_WIDTH            = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  uart_tx_if.slave   bus
);

  localparam int unsigned DW = UART_DATA_LENGTH;
  localparam int unsigned TW = TX_COUNTER_BITWIDTH;
  localparam int unsigned BW = BAUD_RATE_COUNTER_BITWIDTH;
  localparam int unsigned AW = FIFO_ADDR_WIDTH;
  localparam int unsigned CW = FIFO_ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_n;
  logic [BW-1:0] baud_q, baud_n;
  logic [TW-1:0] bit_q, bit_n;
  logic [DW-1:0] shift_q, shift_n;
  logic          tx_q, tx_n;
  logic          busy_q, busy_n;
  logic          ready_q, ready_n;
  logic          ovf_q, ovf_n;
  logic [CW-1:0] count_q, count_n;
  logic [AW-1:0] wr_ptr_q, wr_ptr_n;
  logic [AW-1:0] rd_ptr_q, rd_ptr_n;
  logic [DW-1:0] mem [FIFO_DEPTH];

  logic bit_end_c;
  logic push_c;
  logic pop_c;

  assign bit_end_c = (baud_q == BW'(BAUD_COUNTS_PER_BIT - 1));
  assign push_c    = bus.data_valid_strb_i & ready_q;

  assign bus.tx_o            = tx_q;
  assign bus.busy_o          = busy_q;
  assign bus.ready_o         = ready_q;
  assign bus.fifo_count_o    = count_q;
  assign bus.overflow_strb_o = ovf_q;

  // Next-state: frame sequencing, FIFO bookkeeping and registered outputs.
  always_comb begin
    state_n  = state_q;
    baud_n   = baud_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    tx_n     = tx_q;
    pop_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_n = 1'b1;
        if (count_q != '0) begin
          pop_c   = 1'b1;
          state_n = S_START;
          shift_n = mem[rd_ptr_q];
          tx_n    = 1'b0;
          baud_n  = '0;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_n = S_DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift_q[0];
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          baud_n = '0;
          if (bit_q == TW'(UART_DATA_LENGTH - 1)) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_q + TW'(1);
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
          end
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          baud_n = '0;
          // Chain straight into the next frame when data is waiting.
          if (count_q != '0) begin
            pop_c   = 1'b1;
            state_n = S_START;
            shift_n = mem[rd_ptr_q];
            tx_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    count_n  = count_q + CW'(push_c) - CW'(pop_c);
    wr_ptr_n = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_n = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ready_n  = (count_n != CW'(FIFO_DEPTH));
    busy_n   = (state_n != S_IDLE);
    ovf_n    = bus.data_valid_strb_i & ~ready_q;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_n;
      baud_q   <= baud_n;
      bit_q    <= bit_n;
      shift_q  <= shift_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
      ready_q  <= ready_n;
      ovf_q    <= ovf_n;
      count_q  <= count_n;
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
    end
  end

  // FIFO storage; flushed on reset so no stale byte can resurface.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wr_ptr_q] <= bus.data_i;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx against a frame-level reference model.
module tb_uart_tx;

  localparam int BAUD  = 521;
  localparam int NBITS = 8;
  localparam int FRAME = (NBITS + 2) * BAUD;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  uart_tx_if #(.DATA_W(NBITS), .CNT_W(3)) bus ();

  uart_tx #(
    .UART_DATA_LENGTH          (NBITS),
    .TX_COUNTER_BITWIDTH       (3),
    .BAUD_COUNTS_PER_BIT       (BAUD),
    .BAUD_RATE_COUNTER_BITWIDTH(10),
    .FIFO_DEPTH                (DEPTH),
    .FIFO_ADDR_WIDTH           (2)
  ) u_dut (
    .clk_i  (clk),
    .reset_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of accepted bytes plus position within the current frame.
  logic [7:0] q[$];
  int         frame_rem;
  logic [7:0] cur;
  logic       exp_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_tx();
    int k;
    int b;
    if (frame_rem == 0) return 1'b1;
    k = FRAME - frame_rem;
    b = k / BAUD;
    if (b == 0) return 1'b0;
    if (b <= NBITS) return cur[b-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    frame_rem = 0;
    cur       = 8'h00;
    exp_ovf   = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    logic pop;
    logic acc;
    pop = (q.size() > 0) && (frame_rem <= 1);
    acc = v && (q.size() < DEPTH);
    if (pop) begin
      cur       = q.pop_front();
      frame_rem = FRAME;
    end else if (frame_rem > 0) begin
      frame_rem--;
    end
    if (acc) q.push_back(d);
    exp_ovf = v && !acc;
  endtask

  task automatic compare_all();
    check_eq("tx",       32'(bus.tx_o),            32'(model_tx()));
    check_eq("busy",     32'(bus.busy_o),          32'(frame_rem > 0));
    check_eq("ready",    32'(bus.ready_o),         32'(q.size() < DEPTH));
    check_eq("count",    32'(bus.fifo_count_o),    32'(q.size()));
    check_eq("overflow", 32'(bus.overflow_strb_o), 32'(exp_ovf));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic tick(input logic v, input logic [7:0] d);
    bus.data_valid_strb_i = v;
    bus.data_i            = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    compare_all();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    while ((frame_rem > 0 || q.size() > 0) && i < bound) begin
      tick(1'b0, 8'($urandom));
      i++;
    end
    check_eq("drain_timeout", 32'(i >= bound), 32'(0));
    check_eq("drain_busy", 32'(bus.busy_o), 32'(0));
  endtask

  // Asynchronous reset between edges; outputs must settle before the next edge.
  task automatic mid_cycle_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    run_idle(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int i;
    rst_n = 1'b1;
    bus.data_valid_strb_i = 1'b0;
    bus.data_i = 8'h00;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single 0xA5 frame with data_i churning afterwards.
    tick(1'b1, 8'hA5);
    run_idle(FRAME + 5);

    // Three back-to-back bytes, then a push exactly on a pop edge at count 2.
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h03);
    i = 0;
    while (!(frame_rem == 1 && q.size() == 2) && i < 2 * FRAME) begin
      tick(1'b0, 8'($urandom));
      i++;
    end
    check_eq("wait_pop_edge", 32'(i >= 2 * FRAME), 32'(0));
    tick(1'b1, 8'h04);
    check_eq("simul_count", 32'(bus.fifo_count_o), 32'(2));
    drain(4 * FRAME);

    // Six pushes: fifth fills the FIFO, sixth is dropped with one overflow pulse.
    for (int b = 0; b < 5; b++) tick(1'b1, 8'(8'h10 + b));
    check_eq("full_ready", 32'(bus.ready_o), 32'(0));
    tick(1'b1, 8'h15);
    check_eq("ovf_pulse", 32'(bus.overflow_strb_o), 32'(1));
    tick(1'b0, 8'h00);
    check_eq("ovf_single", 32'(bus.overflow_strb_o), 32'(0));
    run_idle(FRAME + 1500);
    mid_cycle_reset();

    // Reset in the middle of 0x5A data bits with two bytes queued.
    tick(1'b1, 8'h5A);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    run_idle(4 * BAUD + 100);
    check_eq("pre_reset_count", 32'(bus.fifo_count_o), 32'(2));
    mid_cycle_reset();
    check_eq("post_reset_tx", 32'(bus.tx_o), 32'(1));
    run_idle(2000);

    // Random pushes, including overflow and push-on-pop cases.
    for (int r = 0; r < 15000; r++) tick(($urandom % 50) == 0, 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL expose parameter UART_DATA_LENGTH, default 8, as the data bits per frame.
REQ-002 The module SHALL expose parameter TX_COUNTER_BITWIDTH, default 3, as the width of the data-bit index counter.
REQ-003 The module SHALL expose parameter BAUD_COUNTS_PER_BIT, default 521, as the clk_i cycles per bit (10 MHz clock).
REQ-004 The module SHALL expose parameter BAUD_RATE_COUNTER_BITWIDTH, default 10, as the width of the baud counter.
REQ-005 The module SHALL expose parameter FIFO_DEPTH, default 4, as the number of bytes in the transmit FIFO (power of two).
REQ-006 The module SHALL expose parameter FIFO_ADDR_WIDTH, default 2, as log2(FIFO_DEPTH).
REQ-007 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-008 reset_i  input  1  reset; one clock, asynchronous and active-low.
REQ-009 data_i  input  UART_DATA_LENGTH  byte to transmit.
REQ-010 data_valid_strb_i  input  1  push request; data_i is sampled on the same rising edge.
REQ-011 ready_o  output  1  high when the FIFO is not full.
REQ-012 tx_o  output  1  serial line, registered, idle high.
REQ-013 busy_o  output  1  high while a frame is being shifted out (state not IDLE).
REQ-014 fifo_count_o  output  FIFO_ADDR_WIDTH+1  number of bytes stored in the FIFO.
REQ-015 overflow_strb_o  output  1  one-cycle pulse when a push is rejected.

Function
REQ-016 A push SHALL occur on an edge where data_valid_strb_i=1 and ready_o=1; the FIFO SHALL write data_i at the write pointer and increment the pointer modulo FIFO_DEPTH.
REQ-017 A push while full SHALL be dropped, leave the FIFO unchanged, and drive overflow_strb_o high for exactly the next cycle; this SHALL apply even if a pop occurs on the same edge.
REQ-018 A simultaneous push and pop with count<FIFO_DEPTH SHALL leave fifo_count_o unchanged; the pushed byte SHALL be queued behind the popped byte.
REQ-019 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-020 In IDLE with fifo_count_o>0, the next edge SHALL pop the head byte into the shift register, enter START, and drive tx_o=0.
REQ-021 START SHALL hold tx_o=0 for BAUD_COUNTS_PER_BIT cycles, then enter DATA.
REQ-022 DATA SHALL output bits LSB-first, each for BAUD_COUNTS_PER_BIT cycles; after bit UART_DATA_LENGTH-1 it SHALL enter STOP.
REQ-023 STOP SHALL hold tx_o=1 for BAUD_COUNTS_PER_BIT cycles.
REQ-024 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and enter START on the same edge, with no idle cycle between frames; otherwise it SHALL enter IDLE.
REQ-025 The baud counter SHALL count 0..BAUD_COUNTS_PER_BIT-1, reload to 0 at every bit boundary, and never wrap mid-bit.
REQ-026 Frame length SHALL be (UART_DATA_LENGTH+2)*BAUD_COUNTS_PER_BIT cycles, i.e. 5210 cycles by default.
REQ-027 Latency from a push edge into an empty, idle FIFO to tx_o falling SHALL be exactly 1 cycle.
REQ-028 The byte in flight SHALL NOT be affected by later pushes or by data_i changes.

Reset
REQ-029 While reset_i=0, the outputs SHALL be held immediately, independent of clk_i, at: tx_o=1, busy_o=0, ready_o=1, fifo_count_o=0, overflow_strb_o=0; the FSM SHALL be in IDLE, the pointers, baud counter and bit counter SHALL be 0, and the FIFO SHALL be flushed.
REQ-030 Assertion of reset_i mid-frame SHALL abort the frame with tx_o=1, and no partial byte SHALL be retransmitted after release.
REQ-031 The first edge after reset_i rises SHALL accept a push.

Verification
REQ-032 Push 0xA5 when idle -> tx_o = 0,1,0,1,0,0,1,0,1,1, each level for 521 cycles; busy_o high for 5210 cycles, then 0.
REQ-033 Push 0x01, 0x02 and 0x03 on consecutive edges -> three back-to-back frames with no idle gap; fifo_count_o sequence 1,1,2,1,0 at the pop points.
REQ-034 Push 6 bytes back-to-back while idle -> bytes 1-5 accepted (1 popped, 4 queued), ready_o=0 after byte 5, byte 6 dropped with a single overflow_strb_o pulse.
REQ-035 Assert reset_i=0 midway through the data bits of 0x5A with 2 bytes queued -> tx_o=1 immediately, fifo_count_o=0, no further frames after release.
REQ-036 Loop tx_o back into the existing uart_rx (same baud parameters) and push the 8-byte blink program -> uart_rx reports the identical 8 bytes in order.
REQ-037 Simultaneous push and pop at count=2 -> count stays 2 and the FIFO order is preserved.
